// File: rtl/spike_window_classifier_if.sv
// Result/handshake bundle between the spike classifier and its neighbours:
// enable and spike come in, and the classified window result goes out.
interface spike_window_classifier_if #(
  parameter int CNT_W = 16
);
  logic             en_i;
  logic             spike_i;
  logic             ready_i;
  logic [1:0]       class_o;
  logic [CNT_W-1:0] count_o;
  logic             valid_o;
  logic             overrun_o;

  modport master (
    output en_i, spike_i, ready_i,
    input  class_o, count_o, valid_o, overrun_o
  );

  modport slave (
    input  en_i, spike_i, ready_i,
    output class_o, count_o, valid_o, overrun_o
  );
endinterface

// File: rtl/spike_window_classifier.sv
// Counts rising edges of the winner spike over fixed back-to-back windows and
// publishes a saturating count plus a 2-bit class through a valid/ready port.
module spike_window_classifier #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 16,
  parameter int LOW_THR       = 2,
  parameter int HIGH_THR      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  spike_window_classifier_if.slave  bus
);

  localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spk_cnt;
  logic             spike_q;
  logic             rise;
  logic             win_end;
  logic [CNT_W-1:0] spk_total;
  logic [63:0]      total_wide;
  logic [1:0]       result_class;

  assign rise    = bus.spike_i & ~spike_q;
  assign win_end = (state == COUNT) && (win_cnt == WIN_LAST);

  // Count including this cycle's edge, so an edge on the window-end cycle is kept.
  assign spk_total = (rise && (spk_cnt != CNT_MAX)) ? spk_cnt + CNT_W'(1) : spk_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping enable leaves COUNT at once; a window ending on that same cycle
  // still reports because the result path keys only on win_end.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.en_i)  state_next = COUNT;
      COUNT:   if (!bus.en_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      spike_q <= 1'b0;
      win_cnt <= '0;
      spk_cnt <= '0;
    end else begin
      spike_q <= bus.spike_i;
      if ((state == COUNT) && !win_end) begin
        win_cnt <= win_cnt + WIN_W'(1);
        spk_cnt <= spk_total;
      end else begin
        win_cnt <= '0;
        spk_cnt <= '0;
      end
    end
  end

  // Thresholds are compared at 64 bits so they never truncate against a narrow counter.
  always_comb begin
    total_wide   = 64'(spk_total);
    result_class = 2'd1;
    if (spk_total == CNT_MAX) begin
      result_class = 2'd3;
    end else if (total_wide < 64'(LOW_THR)) begin
      result_class = 2'd0;
    end else if (total_wide > 64'(HIGH_THR)) begin
      result_class = 2'd2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus.class_o   <= 2'd0;
      bus.count_o   <= '0;
      bus.valid_o   <= 1'b0;
      bus.overrun_o <= 1'b0;
    end else if (win_end) begin
      if (!bus.valid_o || bus.ready_i) begin
        bus.class_o <= result_class;
        bus.count_o <= spk_total;
        bus.valid_o <= 1'b1;
      end else begin
        bus.overrun_o <= 1'b1;
      end
    end else if (bus.valid_o && bus.ready_i) begin
      bus.valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_window_classifier.sv
// Bench for spike_window_classifier: directed scenarios on a 10-cycle window,
// plus saturation and randomized windows against an edge-counting model.
module tb_spike_window_classifier;

  localparam int LOW  = 2;
  localparam int HIGH = 8;
  localparam int RW   = 24;
  localparam int NWIN = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rnd_spk [RW*NWIN];

  always #5 clk = ~clk;

  spike_window_classifier_if #(.CNT_W(16)) bus_a ();
  spike_window_classifier_if #(.CNT_W(3))  bus_b ();
  spike_window_classifier_if #(.CNT_W(16)) bus_c ();

  spike_window_classifier #(.WINDOW_CYCLES(10), .CNT_W(16), .LOW_THR(LOW), .HIGH_THR(HIGH))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  spike_window_classifier #(.WINDOW_CYCLES(RW), .CNT_W(3), .LOW_THR(LOW), .HIGH_THR(HIGH))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));
  spike_window_classifier #(.WINDOW_CYCLES(RW), .CNT_W(16), .LOW_THR(LOW), .HIGH_THR(HIGH))
    dut_c (.clk_i(clk), .rst_i(rst), .bus(bus_c));

  task automatic tick();
    @(negedge clk);
  endtask

  // Parks dut_a in IDLE with spike low; the next tick lands in window cycle 0.
  task automatic start_a(input bit rdy);
    bus_a.en_i = 1'b0; bus_a.spike_i = 1'b0; bus_a.ready_i = rdy;
    tick(); tick();
    bus_a.en_i = 1'b1;
  endtask

  task automatic start_bc();
    bus_b.en_i = 1'b0; bus_b.spike_i = 1'b0; bus_b.ready_i = 1'b1;
    bus_c.en_i = 1'b0; bus_c.spike_i = 1'b0; bus_c.ready_i = 1'b1;
    tick(); tick();
    bus_b.en_i = 1'b1; bus_c.en_i = 1'b1;
  endtask

  function automatic int edges_in(input int w);
    int n = 0;
    for (int i = w * RW; i < (w + 1) * RW; i++) begin
      if (rnd_spk[i] && !((i == 0) ? 1'b0 : rnd_spk[i-1])) n++;
    end
    return n;
  endfunction

  function automatic logic [1:0] class_of(input int n, input int maxc);
    if (n >= maxc) return 2'd3;
    if (n < LOW)   return 2'd0;
    if (n > HIGH)  return 2'd2;
    return 2'd1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_tests++; if (bus_a.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset valid: got %b want 0", bus_a.valid_o); end
    n_tests++; if (bus_a.overrun_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset overrun: got %b want 0", bus_a.overrun_o); end
    n_tests++; if (bus_a.count_o !== 16'd0) begin n_fail++; $display("[TB] FAIL reset count: got %0d want 0", bus_a.count_o); end
    n_tests++; if (bus_a.class_o !== 2'd0) begin n_fail++; $display("[TB] FAIL reset class: got %0d want 0", bus_a.class_o); end
    n_tests++; if (bus_b.valid_o !== 1'b0 || bus_c.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset valid_bc: got %b%b want 00", bus_b.valid_o, bus_c.valid_o); end
    rst = 1'b1;
  endtask

  task automatic test_normal_window();
    start_a(1'b1);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 9) begin
        n_tests++; if (bus_a.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL normal early valid: got %b want 0", bus_a.valid_o); end
      end
      if (c == 10) begin
        n_tests++; if (bus_a.valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL normal valid: got %b want 1", bus_a.valid_o); end
        n_tests++; if (bus_a.count_o !== 16'd5) begin n_fail++; $display("[TB] FAIL normal count: got %0d want 5", bus_a.count_o); end
        n_tests++; if (bus_a.class_o !== 2'd1) begin n_fail++; $display("[TB] FAIL normal class: got %0d want 1", bus_a.class_o); end
      end
      if (c == 11) begin
        n_tests++; if (bus_a.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL normal valid drop: got %b want 0", bus_a.valid_o); end
      end
      bus_a.spike_i = (c < 10) && (c % 2 == 0);
      bus_a.en_i    = (c < 10);
    end
  endtask

  task automatic test_edge_count();
    start_a(1'b1);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 10) begin
        n_tests++; if (bus_a.count_o !== 16'd2) begin n_fail++; $display("[TB] FAIL edge count: got %0d want 2", bus_a.count_o); end
        n_tests++; if (bus_a.class_o !== 2'd1) begin n_fail++; $display("[TB] FAIL edge class: got %0d want 1", bus_a.class_o); end
      end
      bus_a.spike_i = (c >= 1 && c <= 7) || (c == 9);
      bus_a.en_i    = (c < 10);
    end
  endtask

  task automatic test_backpressure();
    start_a(1'b0);
    for (int c = 0; c < 24; c++) begin
      tick();
      if (c >= 10 && c <= 21) begin
        n_tests++; if (bus_a.valid_o !== 1'b1 || bus_a.count_o !== 16'd3) begin n_fail++; $display("[TB] FAIL backpressure hold c%0d: got valid %b count %0d want 1/3", c, bus_a.valid_o, bus_a.count_o); end
      end
      if (c == 19) begin
        n_tests++; if (bus_a.overrun_o !== 1'b0) begin n_fail++; $display("[TB] FAIL early overrun: got %b want 0", bus_a.overrun_o); end
      end
      if (c == 20 || c == 23) begin
        n_tests++; if (bus_a.overrun_o !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun c%0d: got %b want 1", c, bus_a.overrun_o); end
      end
      if (c == 22) begin
        n_tests++; if (bus_a.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL backpressure release: got %b want 0", bus_a.valid_o); end
      end
      bus_a.spike_i = (c == 1) || (c == 3) || (c == 5) || (c == 12) || (c == 14);
      bus_a.ready_i = (c == 21);
      bus_a.en_i    = (c < 21);
    end
  endtask

  task automatic test_back_to_back();
    bus_a.ready_i = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;
    start_a(1'b0);
    for (int c = 0; c < 23; c++) begin
      tick();
      if (c == 10) begin
        n_tests++; if (bus_a.valid_o !== 1'b1 || bus_a.count_o !== 16'd2) begin n_fail++; $display("[TB] FAIL b2b first: got valid %b count %0d want 1/2", bus_a.valid_o, bus_a.count_o); end
      end
      if (c == 20 || c == 21) begin
        n_tests++; if (bus_a.valid_o !== 1'b1 || bus_a.count_o !== 16'd4) begin n_fail++; $display("[TB] FAIL b2b second c%0d: got valid %b count %0d want 1/4", c, bus_a.valid_o, bus_a.count_o); end
        n_tests++; if (bus_a.overrun_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b overrun c%0d: got %b want 0", c, bus_a.overrun_o); end
      end
      if (c == 22) begin
        n_tests++; if (bus_a.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b drop: got %b want 0", bus_a.valid_o); end
      end
      bus_a.spike_i = (c == 0) || (c == 2) || (c == 11) || (c == 13) || (c == 15) || (c == 17);
      bus_a.ready_i = (c == 19) || (c == 21);
      bus_a.en_i    = (c < 20);
    end
  endtask

  task automatic test_enable_drop();
    start_a(1'b1);
    for (int c = 0; c < 17; c++) begin
      tick();
      if (c >= 6) begin
        n_tests++; if (bus_a.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort valid c%0d: got %b want 0", c, bus_a.valid_o); end
      end
      bus_a.spike_i = (c == 0) || (c == 2) || (c == 4);
      bus_a.en_i    = (c < 5);
    end
    start_a(1'b0);
    for (int c = 0; c < 21; c++) begin
      tick();
      if (c == 10 || c == 14) begin
        n_tests++; if (bus_a.valid_o !== 1'b1 || bus_a.count_o !== 16'd3 || bus_a.class_o !== 2'd1) begin n_fail++; $display("[TB] FAIL en-fall result c%0d: got valid %b count %0d class %0d want 1/3/1", c, bus_a.valid_o, bus_a.count_o, bus_a.class_o); end
      end
      if (c == 15 || c == 20) begin
        n_tests++; if (bus_a.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL en-fall idle c%0d: got %b want 0", c, bus_a.valid_o); end
      end
      bus_a.spike_i = (c == 0) || (c == 2) || (c == 4) || (c == 12);
      bus_a.en_i    = (c < 9);
      bus_a.ready_i = (c >= 14);
    end
  endtask

  task automatic test_reset_mid_window();
    start_a(1'b0);
    for (int c = 0; c < 28; c++) begin
      tick();
      if (c == 14) begin
        n_tests++; if (bus_a.valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL pending before reset: got %b want 1", bus_a.valid_o); end
      end
      if (c == 15) begin
        n_tests++; if (bus_a.valid_o !== 1'b0 || bus_a.count_o !== 16'd0 || bus_a.class_o !== 2'd0 || bus_a.overrun_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset outputs: got valid %b count %0d class %0d overrun %b want all 0", bus_a.valid_o, bus_a.count_o, bus_a.class_o, bus_a.overrun_o); end
      end
      if (c == 25) begin
        n_tests++; if (bus_a.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL post-reset early: got %b want 0", bus_a.valid_o); end
      end
      if (c == 26) begin
        n_tests++; if (bus_a.valid_o !== 1'b1 || bus_a.count_o !== 16'd3) begin n_fail++; $display("[TB] FAIL post-reset window: got valid %b count %0d want 1/3", bus_a.valid_o, bus_a.count_o); end
      end
      rst           = (c != 14);
      bus_a.spike_i = (c == 0) || (c == 2) || (c == 17) || (c == 19) || (c == 21);
      bus_a.ready_i = (c == 26);
      bus_a.en_i    = (c < 26);
    end
  endtask

  task automatic test_saturation();
    start_bc();
    for (int c = 0; c < 50; c++) begin
      tick();
      if (c == 24) begin
        n_tests++; if (bus_b.valid_o !== 1'b1 || bus_b.count_o !== 3'd7 || bus_b.class_o !== 2'd3) begin n_fail++; $display("[TB] FAIL saturate: got valid %b count %0d class %0d want 1/7/3", bus_b.valid_o, bus_b.count_o, bus_b.class_o); end
        n_tests++; if (bus_c.count_o !== 16'd9 || bus_c.class_o !== 2'd2) begin n_fail++; $display("[TB] FAIL high class: got count %0d class %0d want 9/2", bus_c.count_o, bus_c.class_o); end
      end
      if (c == 48) begin
        n_tests++; if (bus_b.valid_o !== 1'b1 || bus_b.count_o !== 3'd0 || bus_b.class_o !== 2'd0) begin n_fail++; $display("[TB] FAIL zero window: got valid %b count %0d class %0d want 1/0/0", bus_b.valid_o, bus_b.count_o, bus_b.class_o); end
        n_tests++; if (bus_c.class_o !== 2'd0) begin n_fail++; $display("[TB] FAIL zero class wide: got %0d want 0", bus_c.class_o); end
      end
      bus_b.spike_i = (c < 18) && (c % 2 == 0);
      bus_c.spike_i = bus_b.spike_i;
      bus_b.en_i    = (c < 48);
      bus_c.en_i    = bus_b.en_i;
    end
  endtask

  task automatic test_random_windows();
    int dens;
    int n;
    for (int w = 0; w < NWIN; w++) begin
      dens = $urandom_range(15, 75);
      for (int i = w * RW; i < (w + 1) * RW; i++) rnd_spk[i] = ($urandom_range(0, 99) < dens);
    end
    start_bc();
    for (int c = 0; c <= RW * NWIN; c++) begin
      tick();
      if (c >= RW && c % RW == 0) begin
        n = edges_in(c / RW - 1);
        n_tests++; if (bus_b.valid_o !== 1'b1 || bus_b.count_o !== 3'((n > 7) ? 7 : n) || bus_b.class_o !== class_of(n, 7)) begin n_fail++; $display("[TB] FAIL random narrow w%0d: got valid %b count %0d class %0d want 1/%0d/%0d", c / RW - 1, bus_b.valid_o, bus_b.count_o, bus_b.class_o, (n > 7) ? 7 : n, class_of(n, 7)); end
        n_tests++; if (bus_c.valid_o !== 1'b1 || bus_c.count_o !== 16'(n) || bus_c.class_o !== class_of(n, 65535)) begin n_fail++; $display("[TB] FAIL random wide w%0d: got valid %b count %0d class %0d want 1/%0d/%0d", c / RW - 1, bus_c.valid_o, bus_c.count_o, bus_c.class_o, n, class_of(n, 65535)); end
      end else if (c > 0) begin
        n_tests++; if (bus_b.valid_o !== 1'b0 || bus_c.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL random idle valid c%0d: got %b%b want 00", c, bus_b.valid_o, bus_c.valid_o); end
      end
      bus_b.spike_i = (c < RW * NWIN) ? rnd_spk[c] : 1'b0;
      bus_c.spike_i = bus_b.spike_i;
      bus_b.en_i    = (c < RW * NWIN);
      bus_c.en_i    = bus_b.en_i;
    end
  endtask

  initial begin
    bus_a.en_i = 1'b0; bus_a.spike_i = 1'b0; bus_a.ready_i = 1'b0;
    bus_b.en_i = 1'b0; bus_b.spike_i = 1'b0; bus_b.ready_i = 1'b0;
    bus_c.en_i = 1'b0; bus_c.spike_i = 1'b0; bus_c.ready_i = 1'b0;
    test_reset();
    test_normal_window();
    test_edge_count();
    test_backpressure();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_window();
    test_saturation();
    test_random_windows();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete within 1 ms");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/spike_window_classifier.md
SPIKE_WINDOW_CLASSIFIER -- requirements
Module: spike_window_classifier

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 1000: clock cycles per counting window, legal range 2 and above.
REQ-002 SHALL have parameter CNT_W, default 16: width of the spike counter and of count_o.
REQ-003 SHALL have parameter LOW_THR, default 2: counts below this value are class 0.
REQ-004 SHALL have parameter HIGH_THR, default 8: counts above this value are class 2; LOW_THR <= HIGH_THR is required.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port en_i, input, 1 bit: enables window counting.
REQ-008 SHALL have port spike_i, input, 1 bit: winner spike from the upstream network, level signal, may stay high for multiple cycles.
REQ-009 SHALL have port class_o, output, 2 bits: window classification.
REQ-010 SHALL have port count_o, output, CNT_W bits: spike count of the reported window.
REQ-011 SHALL have port valid_o, output, 1 bit: result available.
REQ-012 SHALL have port ready_i, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port overrun_o, output, 1 bit: sticky flag, a window result was lost.

Function
REQ-014 SHALL register spike_i once and count only rising edges: spike_i=1 while the registered value was 0.
REQ-015 SHALL use FSM states IDLE and COUNT.
REQ-016 IDLE -> COUNT: when en_i=1; the window cycle counter and spike counter clear to 0 on entry.
REQ-017 In COUNT, the window counter SHALL increment every cycle; the cycle where it equals WINDOW_CYCLES-1 is the window-end cycle.
REQ-018 A rising edge on the window-end cycle SHALL be included in that window.
REQ-019 At window end, both counters SHALL restart at 0 on the next cycle with no dead cycle; windows are back-to-back.
REQ-020 The spike counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 Classification of count c: class 0 if c < LOW_THR; class 1 if LOW_THR <= c <= HIGH_THR; class 2 if c > HIGH_THR; class 3 if the counter saturated, which overrides the other classes.
REQ-022 The result SHALL be registered into class_o and count_o, with valid_o=1, on the cycle after window end: latency is 1 cycle.
REQ-023 Handshake: a transfer occurs on a cycle where valid_o=1 and ready_i=1; valid_o falls on the next cycle unless a new result loads.
REQ-024 While valid_o=1 without a transfer, class_o and count_o SHALL hold stable.
REQ-025 Window end while valid_o=1 with no transfer in that cycle: the new result SHALL be dropped, the old result held, and overrun_o set to 1.
REQ-026 Window end in the same cycle as a transfer: the new result SHALL load and valid_o stays 1; no overrun.
REQ-027 overrun_o SHALL stay set until reset.
REQ-028 en_i=0 in COUNT: return to IDLE next cycle and discard the partial window; a pending valid result is held until accepted.
REQ-029 en_i falling on the window-end cycle: that window's result SHALL still be produced.
REQ-030 ready_i SHALL be ignored while valid_o=0.

Reset
REQ-031 On rst_i=0 at a clock edge: FSM=IDLE; all counters and the spike register at 0; class_o=0, count_o=0, valid_o=0, overrun_o=0.
REQ-032 Reset SHALL take priority over all other inputs, including mid-window and mid-handshake; a pending result is discarded.

Verification
REQ-033 Normal window: WINDOW_CYCLES=10, en_i=1, 5 single-cycle spikes, ready_i=1 -> one cycle after window end, valid_o=1, count_o=5, class_o=1, then valid_o=0.
REQ-034 Edge counting: spike_i held high 7 cycles, then one more 1-cycle pulse in the same window -> count_o=2, class_o=1.
REQ-035 Back-pressure and overrun: ready_i=0 across two window ends -> first result held stable, second dropped, overrun_o=1; a later ready_i=1 delivers the first result.
REQ-036 Simultaneous transfer and window end: ready_i=1 exactly on the window-end cycle with a result pending -> valid_o stays 1, new count_o shown, overrun_o=0.
REQ-037 Saturation and thresholds: CNT_W=3, 9 spikes -> count_o=7, class_o=3; 0 spikes -> class_o=0; 9 spikes with CNT_W=16 -> class_o=2.
REQ-038 Reset mid-window: rst_i=0 for 1 cycle at window cycle 4 with valid_o=1 -> all outputs 0 next cycle; with en_i=1, a full new window starts after reset is released.
